iterative_left_shifter: RTL

- Multi-cycle logical left shifter, 1 bit per clock. It is the left-direction companion to the existing single-bit arithmetic right-shift stage.
- Sits in the multicycle ALU path and serves SLL when area matters more than latency.
- A start/busy/done handshake toward the ALU controller replaces a full barrel shifter.

---
 rtl/iterative_left_shifter.sv | 113 +++++++++++
 1 files changed

// File: rtl/iterative_left_shifter.sv
// Multi-cycle logical left shifter (1 bit per clock) with a start/busy/done handshake.
// Optional signed-overflow flag `ovf` is compiled in with the macro SLL_OVERFLOW_EN.
module iterative_left_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
`ifdef SLL_OVERFLOW_EN
    output logic               ovf,
`endif
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = SHAMT_W'(1'b0);
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1'b1);

    state_t             state_r;
    logic [WIDTH-1:0]   result_r;
    logic [SHAMT_W-1:0] count_r;
    logic               busy_r;
    logic               done_r;
`ifdef SLL_OVERFLOW_EN
    logic               ovf_r;
`endif

    // Control FSM and datapath; busy/done are decoded one edge early so they stay registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= IDLE;
            result_r <= {WIDTH{1'b0}};
            count_r  <= CNT_ZERO;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef SLL_OVERFLOW_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    if (start) begin
                        result_r <= data_in;
                        count_r  <= shamt;
`ifdef SLL_OVERFLOW_EN
                        ovf_r    <= 1'b0;
`endif
                        if (shamt == CNT_ZERO) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= SHIFT;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    result_r <= {result_r[WIDTH-2:0], 1'b0};
                    // count never goes below 1 here, so the decrement cannot wrap
                    count_r  <= count_r - CNT_ONE;
`ifdef SLL_OVERFLOW_EN
                    if (result_r[WIDTH-1] != result_r[WIDTH-2]) begin
                        ovf_r <= 1'b1;
                    end else begin
                        ovf_r <= ovf_r;
                    end
`endif
                    if (count_r == CNT_ONE) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= SHIFT;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_r;
    assign busy   = busy_r;
    assign done   = done_r;
`ifdef SLL_OVERFLOW_EN
    assign ovf    = ovf_r;
`endif

endmodule
